mem_access: RTL and testbench

//   Memory-access stage directly downstream of ex. Consumes ex's load/store outputs, runs one
//   req/ack transaction per access on the data bus, and returns load data as a register write.

---
 rtl/mem_access.sv | 144 ++++++++++++++
 tb/tb_mem_access.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage; one req/ack bus transaction per load/store, load write-back,
// alignment and bus-timeout error pulses. Rev 1.0
`default_nettype none

module mem_access #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_load_en,
    input  logic [XLEN-1:0] mem_load_addr,
    input  logic [4:0]      mem_load_regs_addr,
    input  logic [1:0]      mem_store_mode,
    input  logic [XLEN-1:0] mem_store_addr,
    input  logic [XLEN-1:0] mem_store_data,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_wstrb,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            regs_write_en,
    output logic [4:0]      regs_write_addr,
    output logic [XLEN-1:0] regs_write_data,
    output logic            pause_signal,
    output logic            misalign_err,
    output logic            bus_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] WB    = 2'd3;
    localparam int         CW    = $clog2(TIMEOUT + 1);

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata_q;

    logic            load_bad, store_bad, load_ok, store_ok;
    logic            accept, reject, timeout_hit;
    logic [3:0]      wstrb_n;
    logic [XLEN-1:0] wdata_n;

    // A concurrent load request always wins; the store is then dropped entirely.
    always_comb begin
        load_bad  = mem_load_en && (mem_load_addr[1:0] != 2'b00);
        load_ok   = mem_load_en && (mem_load_addr[1:0] == 2'b00);
        store_bad = !mem_load_en &&
                    (((mem_store_mode == 2'b10) && mem_store_addr[0]) ||
                     ((mem_store_mode == 2'b11) && (mem_store_addr[1:0] != 2'b00)));
        store_ok  = !mem_load_en && (mem_store_mode != 2'b00) && !store_bad;
        accept    = (state == IDLE) && (load_ok || store_ok);
        reject    = (state == IDLE) && (load_bad || store_bad);
        timeout_hit = (cnt == CW'(TIMEOUT - 1));
        case (mem_store_mode)
            2'b01: begin
                wstrb_n = 4'b0001 << mem_store_addr[1:0];
                wdata_n = {(XLEN/8){mem_store_data[7:0]}};
            end
            2'b10: begin
                wstrb_n = 4'b0011 << mem_store_addr[1:0];
                wdata_n = {(XLEN/16){mem_store_data[15:0]}};
            end
            default: begin
                wstrb_n = 4'b1111;
                wdata_n = mem_store_data;
            end
        endcase
    end

    assign pause_signal    = rst_n && (accept || (state == LOAD) || (state == STORE));
    assign regs_write_en   = (state == WB) && (rd != 5'd0);
    assign regs_write_addr = rd;
    assign regs_write_data = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rd           <= '0;
            rdata_q      <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wstrb    <= '0;
            bus_wdata    <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= reject;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        bus_req <= 1'b1;
                        if (load_ok) begin
                            state     <= LOAD;
                            rd        <= mem_load_regs_addr;
                            bus_we    <= 1'b0;
                            bus_addr  <= {mem_load_addr[XLEN-1:2], 2'b00};
                            bus_wstrb <= 4'b0000;
                            bus_wdata <= '0;
                        end else begin
                            state     <= STORE;
                            bus_we    <= 1'b1;
                            bus_addr  <= {mem_store_addr[XLEN-1:2], 2'b00};
                            bus_wstrb <= wstrb_n;
                            bus_wdata <= wdata_n;
                        end
                    end
                end
                LOAD, STORE: begin
                    // An ack in the final allowed cycle still completes the access.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        if (state == LOAD) begin
                            rdata_q <= bus_rdata;
                            state   <= WB;
                        end else begin
                            state   <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access with a random-latency bus responder.
`default_nettype none

module tb_mem_access;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_load_en = 1'b0;
    logic [31:0] mem_load_addr = '0;
    logic [4:0]  mem_load_regs_addr = '0;
    logic [1:0]  mem_store_mode = '0;
    logic [31:0] mem_store_addr = '0;
    logic [31:0] mem_store_data = '0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        regs_write_en;
    logic [4:0]  regs_write_addr;
    logic [31:0] regs_write_data;
    logic        pause_signal, misalign_err, bus_err;

    mem_access #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_load_en(mem_load_en), .mem_load_addr(mem_load_addr),
        .mem_load_regs_addr(mem_load_regs_addr), .mem_store_mode(mem_store_mode),
        .mem_store_addr(mem_store_addr), .mem_store_data(mem_store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .regs_write_en(regs_write_en), .regs_write_addr(regs_write_addr),
        .regs_write_data(regs_write_data), .pause_signal(pause_signal),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          len;   // expected cycles of bus_req; 0 = not checked
    } bus_item_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_item_t;

    bus_item_t bus_q[$];
    wb_item_t  wb_q[$];
    int        err_q[$];   // 1 = misalign, 2 = bus timeout

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus responder: acks on the Nth cycle of a request (N = ack_delay, 0 = never),
    // and toggles spurious acks while no request is pending.
    int          ack_delay = 1;
    logic [31:0] rdata_val = '0;
    int          req_cycles = 0;

    always @(negedge clk) begin
        if (bus_req) begin
            req_cycles++;
            bus_ack   = (ack_delay != 0) && (req_cycles == ack_delay);
            bus_rdata = bus_ack ? rdata_val : $urandom;
        end else begin
            req_cycles = 0;
            bus_ack    = ($urandom_range(0, 3) == 0);
            bus_rdata  = $urandom;
        end
    end

    // Monitor: pops expectations whenever the DUT shows an observable event.
    logic      prev_req = 1'b0;
    int        req_len = 0;
    bus_item_t cur;
    wb_item_t  wexp;
    int        eexp;

    always @(negedge clk) begin
        if (bus_req) begin
            if (!prev_req) begin
                req_len = 0;
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_req", 64'd1, 64'd0);
                    cur = '{we: bus_we, addr: bus_addr, strb: bus_wstrb, wdata: bus_wdata, len: 0};
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            req_len++;
            chk("bus_we", 64'(bus_we), 64'(cur.we));
            chk("bus_addr", 64'(bus_addr), 64'(cur.addr));
            chk("bus_wstrb", 64'(bus_wstrb), 64'(cur.strb));
            if (cur.we) chk("bus_wdata", 64'(bus_wdata), 64'(cur.wdata));
        end else if (prev_req && cur.len != 0) begin
            chk("req_length", 64'(req_len), 64'(cur.len));
        end
        prev_req = bus_req;

        if (regs_write_en) begin
            chk("wb_pause_released", 64'(pause_signal), 64'd0);
            if (wb_q.size() == 0) chk("unexpected_write_back", 64'(regs_write_addr), 64'd0);
            else begin
                wexp = wb_q.pop_front();
                chk("wb_addr", 64'(regs_write_addr), 64'(wexp.addr));
                chk("wb_data", 64'(regs_write_data), 64'(wexp.data));
            end
        end
        if (misalign_err || bus_err) begin
            eexp = (err_q.size() == 0) ? 0 : err_q.pop_front();
            chk("error_kind", {62'd0, bus_err, misalign_err}, 64'(eexp));
        end
    end

    // Reference model: byte lanes covered by [off, off+size) and data bytes repeated across lanes.
    task automatic do_op(input bit is_load, input logic [1:0] mode, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] data, input int delay,
                         input bit both, input int gap);
        int          nbytes, off;
        bit          bad;
        bus_item_t   bi;
        logic [3:0]  strb;
        logic [31:0] wd;
        off    = int'(addr[1:0]);
        nbytes = is_load ? 4 : (mode == 2'b01 ? 1 : (mode == 2'b10 ? 2 : 4));
        bad    = (off % nbytes) != 0;
        strb   = '0;
        wd     = '0;
        for (int i = 0; i < 4; i++) begin
            wd[8*i +: 8] = data[8*(i % nbytes) +: 8];
            if (!is_load && i >= off && i < off + nbytes) strb[i] = 1'b1;
        end
        if (bad) err_q.push_back(1);
        else begin
            bi = '{we: !is_load, addr: {addr[31:2], 2'b00}, strb: strb, wdata: wd,
                   len: (delay == 0) ? TIMEOUT : delay};
            bus_q.push_back(bi);
            if (delay == 0) err_q.push_back(2);
            else if (is_load && rd != 5'd0) wb_q.push_back('{addr: rd, data: data});
        end
        ack_delay = delay;
        rdata_val = data;
        if (is_load) begin
            mem_load_en        = 1'b1;
            mem_load_addr      = addr;
            mem_load_regs_addr = rd;
            mem_store_mode     = both ? 2'b11 : 2'b00;
            mem_store_addr     = $urandom;
            mem_store_data     = $urandom;
        end else begin
            mem_store_mode = mode;
            mem_store_addr = addr;
            mem_store_data = data;
        end
        #1 chk("pause_on_accept", 64'(pause_signal), 64'(!bad));
        @(negedge clk);
        mem_load_en    = 1'b0;
        mem_store_mode = 2'b00;
        for (int i = 0; i < 40 && bus_req; i++) @(negedge clk);
        if (bus_req) chk("access_never_ended", 64'(bus_req), 64'd0);
        if (!bad && is_load && delay != 0) @(negedge clk);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, regs_write_en, regs_write_addr,
             pause_signal, misalign_err, bus_err} == '0 ? 64'd0 : 64'd1, 64'd0);
        chk("reset_wb_data", 64'(regs_write_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1, 2'b00, 32'h100, 5'd5, 32'hDEADBEEF, 3, 0, 1);
        do_op(0, 2'b01, 32'h203, 5'd0, 32'h000000A5, 2, 0, 1);
        do_op(0, 2'b10, 32'h201, 5'd0, 32'h00001234, 1, 0, 1);
        do_op(1, 2'b00, 32'h102, 5'd3, 32'h11111111, 1, 0, 1);
        do_op(1, 2'b00, 32'h040, 5'd7, 32'h22222222, 0, 0, 1);
        do_op(1, 2'b00, 32'h080, 5'd0, 32'h33333333, 1, 0, 0);
        do_op(0, 2'b11, 32'h010, 5'd0, 32'hCAFEF00D, 1, 0, 1);
        do_op(1, 2'b00, 32'h0C0, 5'd12, 32'h44444444, 2, 1, 1);

        // Reset in the middle of a load: no write-back and no error may follow.
        ack_delay = 0;
        bus_q.push_back('{we: 1'b0, addr: 32'h300, strb: 4'b0000, wdata: 32'h0, len: 0});
        mem_load_en = 1'b1; mem_load_addr = 32'h300; mem_load_regs_addr = 5'd9;
        @(negedge clk);
        mem_load_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("reset_drops_req", 64'(bus_req), 64'd0);
        chk("reset_drops_pause", 64'(pause_signal), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(1, 2'b00, 32'h304, 5'd9, 32'h55AA55AA, 2, 0, 1);

        for (int n = 0; n < 60; n++) begin
            bit          ld;
            logic [1:0]  md;
            logic [31:0] ad;
            ld = ($urandom_range(0, 1) == 1);
            md = 2'($urandom_range(1, 3));
            ad = {20'd0, 12'($urandom)};
            if (ld && $urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
            do_op(ld, md, ad, 5'($urandom), $urandom,
                  ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
        end

        repeat (3) @(negedge clk);
        chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        chk("err_queue_drained", 64'(err_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
